// File: rtl/vecmac_pkg.sv
// Shared constants and result record for the vector MAC accumulator.
// Lane geometry of the 4x8x8 multiplier product word and default record widths.
// No logic here; types and constants only.
package vecmac_pkg;

    localparam int LANES     = 4;
    localparam int LANE_W    = 16;
    localparam int LSUM_W    = 18;

    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 8;

    // Result record at default widths; the top builds the same shape at its own widths.
    typedef struct packed {
        logic [ACC_W_DEF-1:0] acc;
        logic [CNT_W_DEF-1:0] cnt;
        logic                 sat;
    } res_t;

endpackage

// File: rtl/vecmac_res_fifo.sv
// Purpose: 2-entry in-order result FIFO.
// Latency: a push is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: never stalls the writer; a push into a full FIFO without a pop is ignored.
module vecmac_res_fifo
    import vecmac_pkg::*;
#(
    parameter type dat_t = res_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  dat_t push_dat_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output dat_t head_o
);

    dat_t       mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_q];

    // A pop frees the head slot on the same edge, so a full FIFO can still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy bookkeeping.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vecmac_accum.sv
// Purpose: reduce 4 lane products per beat and accumulate per vector into a result FIFO.
// Latency: last beat sampled at edge t0 reaches out_valid after edge t0+1 (FIFO empty).
// Backpressure: never stalls upstream; results hitting a full FIFO are dropped, err_overrun set.
module vecmac_accum
    import vecmac_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int SAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [63:0]        product,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [CNT_W-1:0]   out_cnt,
    output logic               out_sat,
    output logic               err_overrun
);

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } rec_t;

    logic [LSUM_W-1:0] lane_sum;
    logic [LSUM_W-1:0] s1_sum_q;
    logic              s1_last_q;
    logic              s1_vld_q;

    logic [ACC_W:0]    nxt_wide;
    logic [ACC_W-1:0]  nxt;
    logic              sat_now;
    logic [CNT_W-1:0]  cnt_inc;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              err_q;

    logic              push;
    logic              pop;
    logic              overrun;
    logic              fifo_full;
    logic              fifo_empty;
    rec_t              push_rec;
    rec_t              head_rec;

    // Lane reduction: four 16-bit products fit in 18 bits without overflow.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + LSUM_W'(product[i*LANE_W +: LANE_W]);
        end
    end

    // Stage 1 register; clear drops whatever beat is present on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_sum_q  <= '0;
        end else begin
            s1_vld_q <= in_valid && !clear;
            if (in_valid && !clear) begin
                s1_sum_q  <= lane_sum;
                s1_last_q <= in_last;
            end
        end
    end

    // Accumulate with one carry bit, then clamp or wrap; beat count saturates.
    always_comb begin
        nxt_wide = {1'b0, acc_q} + {{(ACC_W + 1 - LSUM_W){1'b0}}, s1_sum_q};
        nxt      = nxt_wide[ACC_W-1:0];
        sat_now  = 1'b0;
        if (SAT != 0 && nxt_wide[ACC_W]) begin
            nxt     = '1;
            sat_now = 1'b1;
        end
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Stage 2 next state: clear wins, a last beat emits a record and restarts the vector.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        push  = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (s1_vld_q) begin
            if (s1_last_q) begin
                acc_d = '0;
                cnt_d = '0;
                sat_d = 1'b0;
                push  = 1'b1;
            end else begin
                acc_d = nxt;
                cnt_d = cnt_inc;
                sat_d = sat_q | sat_now;
            end
        end
    end

    assign push_rec = '{acc: nxt, cnt: cnt_inc, sat: sat_q | sat_now};
    assign pop      = out_ready && !fifo_empty;
    assign overrun  = push && fifo_full && !pop;

    // Accumulator state and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            err_q <= err_q | overrun;
        end
    end

    vecmac_res_fifo #(
        .dat_t (rec_t)
    ) u_res_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_rec),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head_rec)
    );

    assign out_valid   = !fifo_empty;
    assign out_acc     = head_rec.acc;
    assign out_cnt     = head_rec.cnt;
    assign out_sat     = head_rec.sat;
    assign err_overrun = err_q;

endmodule
